// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line, read-only instruction cache.
// Hits return data combinationally from IDLE; a miss moves to FETCH and holds
// iREN/iaddr until the arbiter lowers iwait, then writes the line.
// Optional build macro ICACHE_STATS_EN adds the hit_count/miss_count outputs.
module icache_direct #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      miss_addr_q, miss_addr_d;
    logic             flush_pend_q, flush_pend_d;
    logic [SETS-1:0]  valid_q, valid_d;

    // Tag and data arrays carry no reset; only the valid bits do.
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             lookup_hit;
    logic             fill_we;
    logic [SETS-1:0]  fill_sel;
    logic [1:0]       unused_byte_off;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];

    // Byte offset never takes part in lookup or fill.
    assign unused_byte_off = imemaddr[1:0];

    assign lookup_hit = valid_q[req_idx] & (tag_q[req_idx] == req_tag);

    // One-hot decode of the line being filled, used to set its valid bit.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_fill_sel
        assign fill_sel[gi] = (fill_idx == IDX_W'(gi));
    end

    // Next-state and output decode for the IDLE/FETCH controller.
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        ihit         = 1'b0;
        imemload     = 32'd0;
        iREN         = 1'b0;
        iaddr        = 32'd0;
        fill_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (imemREN && lookup_hit) begin
                    ihit     = 1'b1;
                    imemload = data_q[req_idx];
                end else if (imemREN) begin
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                    state_d     = FETCH;
                end
                // The lookup above still sees the pre-flush contents.
                if (flush) begin
                    valid_d = '0;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                    // A flush seen at any point during the fill, including
                    // this last cycle, also wipes the line just filled.
                    if (flush_pend_q || flush) begin
                        valid_d      = '0;
                        flush_pend_d = 1'b0;
                    end else begin
                        valid_d = valid_q | fill_sel;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state, latched miss address, pending flush and valid bits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            miss_addr_q  <= 32'd0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
        end
    end

    // Line write on fill completion; reset forces IDLE so no write can occur.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;
    logic        miss_start;

    assign miss_start = (state_q == IDLE) && (state_d == FETCH);

    // Free-running event counters; they wrap and ignore flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            if (ihit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (miss_start) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed vector table, hand-written corner-case
// sequences, then randomized traffic checked against a behavioural cache model.
`timescale 1ns/1ps
module tb_icache_direct;

    localparam int SETS  = 16;
    localparam int IDX_W = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_direct #(.SETS(SETS)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .flush    (flush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    // Each line remembers the full word address it holds, so a hit is simply
    // "line valid and same word address".
    logic        mv   [SETS];
    logic [29:0] mwa  [SETS];
    logic [31:0] md   [SETS];
    logic        mbusy;
    logic [29:0] mbwa;
    logic        mpend;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    logic        e_ihit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic int midx(input logic [31:0] a);
        return int'(a[IDX_W+1:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
        mbusy    = 1'b0;
        mpend    = 1'b0;
        mbwa     = '0;
        m_hits   = 32'd0;
        m_misses = 32'd0;
    endtask

    task automatic model_expect();
        int i;
        if (mbusy) begin
            e_ihit  = 1'b0;
            e_load  = 32'd0;
            e_iren  = 1'b1;
            e_iaddr = {mbwa, 2'b00};
        end else begin
            i       = midx(imemaddr);
            e_ihit  = imemREN && mv[i] && (mwa[i] == imemaddr[31:2]);
            e_load  = e_ihit ? md[i] : 32'd0;
            e_iren  = 1'b0;
            e_iaddr = 32'd0;
        end
    endtask

    task automatic model_update();
        int i;
        if (mbusy) begin
            if (flush) mpend = 1'b1;
            if (!iwait) begin
                i      = int'(mbwa[IDX_W-1:0]);
                mv[i]  = 1'b1;
                mwa[i] = mbwa;
                md[i]  = iload;
                mbusy  = 1'b0;
                if (mpend) begin
                    for (int k = 0; k < SETS; k++) mv[k] = 1'b0;
                    mpend = 1'b0;
                end
            end
        end else begin
            if (e_ihit) m_hits = m_hits + 32'd1;
            if (flush) begin
                for (int k = 0; k < SETS; k++) mv[k] = 1'b0;
            end
            if (imemREN && !e_ihit) begin
                mbusy    = 1'b1;
                mbwa     = imemaddr[31:2];
                m_misses = m_misses + 32'd1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, let outputs settle, compare to model.
    task automatic apply(input logic ren, input logic [31:0] a, input logic fl,
                         input logic w, input logic [31:0] ld);
        imemREN  = ren;
        imemaddr = a;
        flush    = fl;
        iwait    = w;
        iload    = ld;
        #1;
        model_expect();
        chk("m_ihit", {31'd0, ihit}, {31'd0, e_ihit});
        chk("m_imemload", imemload, e_load);
        chk("m_iREN", {31'd0, iREN}, {31'd0, e_iren});
        chk("m_iaddr", iaddr, e_iaddr);
`ifdef ICACHE_STATS_EN
        chk("m_hit_count", hit_count, m_hits);
        chk("m_miss_count", miss_count, m_misses);
`endif
    endtask

    task automatic next();
        model_update();
        @(negedge CLK);
    endtask

    // Second cycle of a miss: arbiter answers immediately with the word.
    task automatic complete(input logic [31:0] a);
        apply(1'b1, a, 1'b0, 1'b0, memf(a));
        next();
    endtask

    // Full miss: detect cycle, `waits` busy cycles, then the answer.
    task automatic fill(input logic [31:0] a, input int waits);
        apply(1'b1, a, 1'b0, 1'b1, 32'd0);
        next();
        for (int k = 0; k < waits; k++) begin
            apply(1'b1, a, 1'b0, 1'b1, 32'd0);
            next();
        end
        complete(a);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        fl;
        logic        w;
        logic [31:0] ld;
        logic        x_hit;
        logic [31:0] x_load;
        logic        x_ren;
        logic [31:0] x_iaddr;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic        ren, fl, w;
        logic [31:0] ld;

        tbl[0]  = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40};
        tbl[2]  = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40};
        tbl[3]  = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40};
        tbl[4]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h8C010004, 1'b0, 32'h0,        1'b1, 32'h40};
        tbl[5]  = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b1, 32'h8C010004, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 32'h440, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        tbl[7]  = '{1'b1, 32'h440, 1'b0, 1'b0, 32'h11111111, 1'b0, 32'h0,        1'b1, 32'h440};
        tbl[8]  = '{1'b1, 32'h440, 1'b0, 1'b1, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 32'h43,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        tbl[10] = '{1'b1, 32'h43,  1'b0, 1'b0, 32'h22222222, 1'b0, 32'h0,        1'b1, 32'h40};
        tbl[11] = '{1'b1, 32'h41,  1'b0, 1'b1, 32'h0,        1'b1, 32'h22222222, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 32'h440, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        tbl[13] = '{1'b1, 32'h440, 1'b0, 1'b0, 32'h33333333, 1'b0, 32'h0,        1'b1, 32'h440};
        tbl[14] = '{1'b1, 32'h440, 1'b0, 1'b1, 32'h0,        1'b1, 32'h33333333, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 32'h440, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};

        // Reset state, with a request already asserted.
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b0;
        iwait = 1'b1; iload = 32'd0;
        model_reset();
        @(negedge CLK);
        #1;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
`endif
        @(negedge CLK);
        nRST = 1'b1;

        // Miss with 3 busy cycles, conflict eviction, byte-offset handling.
        for (int k = 0; k < 16; k++) begin
            apply(tbl[k].ren, tbl[k].addr, tbl[k].fl, tbl[k].w, tbl[k].ld);
            chk($sformatf("vec%0d_ihit", k), {31'd0, ihit}, {31'd0, tbl[k].x_hit});
            chk($sformatf("vec%0d_imemload", k), imemload, tbl[k].x_load);
            chk($sformatf("vec%0d_iREN", k), {31'd0, iREN}, {31'd0, tbl[k].x_ren});
            chk($sformatf("vec%0d_iaddr", k), iaddr, tbl[k].x_iaddr);
            $display("vec %0d addr=%h iwait=%0d ihit=%0d imemload=%h iREN=%0d iaddr=%h",
                     k, tbl[k].addr, tbl[k].w, ihit, imemload, iREN, iaddr);
            next();
        end

        // Flush during FETCH wipes everything, including the fill itself.
        fill(32'h84, 1);
        apply(1'b1, 32'h84, 1'b0, 1'b1, 32'd0);
        chk("pre_flush_hit84", {31'd0, ihit}, 32'd1);
        chk("pre_flush_load84", imemload, memf(32'h84));
        next();
        apply(1'b1, 32'h80, 1'b0, 1'b1, 32'd0);
        next();
        apply(1'b1, 32'h80, 1'b1, 1'b1, 32'd0);
        chk("flush_fetch_iREN", {31'd0, iREN}, 32'd1);
        chk("flush_fetch_iaddr", iaddr, 32'h80);
        next();
        apply(1'b1, 32'h80, 1'b0, 1'b0, memf(32'h80));
        next();
        apply(1'b1, 32'h80, 1'b0, 1'b1, 32'd0);
        chk("flush_refill_miss", {31'd0, ihit}, 32'd0);
        chk("flush_iREN_dropped", {31'd0, iREN}, 32'd0);
        next();
        complete(32'h80);
        apply(1'b1, 32'h84, 1'b0, 1'b1, 32'd0);
        chk("flush_other_line_miss", {31'd0, ihit}, 32'd0);
        next();
        complete(32'h84);
        $display("seq flush-in-fetch done");

        // Flush coinciding with fill completion.
        apply(1'b1, 32'h88, 1'b0, 1'b1, 32'd0);
        next();
        apply(1'b1, 32'h88, 1'b1, 1'b0, memf(32'h88));
        next();
        apply(1'b1, 32'h88, 1'b0, 1'b1, 32'd0);
        chk("coincident_flush_miss", {31'd0, ihit}, 32'd0);
        next();
        complete(32'h88);

        // Flush in IDLE: that cycle's lookup still hits, the next one misses.
        apply(1'b1, 32'h88, 1'b1, 1'b1, 32'd0);
        chk("idle_flush_cycle_hit", {31'd0, ihit}, 32'd1);
        next();
        apply(1'b1, 32'h88, 1'b0, 1'b1, 32'd0);
        chk("after_idle_flush_miss", {31'd0, ihit}, 32'd0);
        next();
        complete(32'h88);
        $display("seq flush-coincident/idle done");

        // Branch redirect mid-FETCH does not disturb the outstanding fill.
        apply(1'b1, 32'h100, 1'b0, 1'b1, 32'd0);
        next();
        for (int k = 0; k < 2; k++) begin
            apply(1'b1, 32'h200, 1'b0, 1'b1, 32'd0);
            chk("redirect_iaddr_hold", iaddr, 32'h100);
            chk("redirect_no_bypass", {31'd0, ihit}, 32'd0);
            next();
        end
        apply(1'b1, 32'h200, 1'b0, 1'b0, memf(32'h100));
        chk("redirect_iaddr_done", iaddr, 32'h100);
        next();
        apply(1'b1, 32'h100, 1'b0, 1'b1, 32'd0);
        chk("redirect_filled_hit", {31'd0, ihit}, 32'd1);
        chk("redirect_filled_load", imemload, memf(32'h100));
        next();
        apply(1'b1, 32'h200, 1'b0, 1'b1, 32'd0);
        chk("redirect_target_miss", {31'd0, ihit}, 32'd0);
        next();
        complete(32'h200);
        fill(32'h100, 0);
        $display("seq redirect done");

        // Reset asserted mid-FETCH abandons the fill.
        apply(1'b1, 32'h140, 1'b0, 1'b1, 32'd0);
        next();
        apply(1'b1, 32'h140, 1'b0, 1'b1, 32'd0);
        chk("pre_rst_iREN", {31'd0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("midrst_iREN", {31'd0, iREN}, 32'd0);
        chk("midrst_ihit", {31'd0, ihit}, 32'd0);
        chk("midrst_iaddr", iaddr, 32'd0);
        model_reset();
        iwait = 1'b0;
        iload = memf(32'h140);
        @(negedge CLK);
        nRST = 1'b1;
        apply(1'b1, 32'h100, 1'b0, 1'b1, 32'd0);
        chk("post_rst_miss", {31'd0, ihit}, 32'd0);
        next();
        complete(32'h100);
        $display("seq reset-mid-fetch done");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ren = ($urandom_range(0, 9) != 0);
            a   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3)) | (($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'd0);
            fl  = ($urandom_range(0, 39) == 0);
            w   = mbusy ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
            ld  = mbusy ? memf({mbwa, 2'b00}) : 32'($urandom);
            apply(ren, a, fl, w, ld);
            next();
        end
        $display("random phase done");

`ifdef ICACHE_STATS_EN
        // Miss counter wraps from all-ones to zero.
        for (int k = 0; k < 4 && mbusy; k++) begin
            apply(1'b0, 32'd0, 1'b0, 1'b0, memf({mbwa, 2'b00}));
            next();
        end
        apply(1'b0, 32'd0, 1'b1, 1'b1, 32'd0);
        next();
        dut.miss_count_q = 32'hFFFFFFFF;
        m_misses = 32'hFFFFFFFF;
        apply(1'b1, 32'h40, 1'b0, 1'b1, 32'd0);
        next();
        apply(1'b1, 32'h40, 1'b0, 1'b0, memf(32'h40));
        chk("miss_count_wrap", miss_count, 32'd0);
        next();
        $display("seq stats wrap done");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
